// File: rtl/i2c_reg_file_if.sv
// Per-byte event bus between the I2C slave byte engine (master) and the register bank (slave).
interface i2c_reg_file_if;
    logic       i2c_start;
    logic       i2c_stop;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       tx_req;
    logic [7:0] tx_data;
    logic       tx_valid;

    modport master (
        output i2c_start, i2c_stop, rx_valid, rx_data, tx_req,
        input  tx_data, tx_valid
    );

    modport slave (
        input  i2c_start, i2c_stop, rx_valid, rx_data, tx_req,
        output tx_data, tx_valid
    );
endinterface

// File: rtl/i2c_reg_file.sv
// Byte-addressed register bank behind the I2C slave engine, with a parallel fabric port.
// Optional feature: define I2C_REGFILE_IRQ_EN for an end-of-write-transaction irq pulse.
module i2c_reg_file #(
    parameter int         NUM_REGS = 32,
    parameter logic [7:0] DEV_ID   = 8'hA5,
    localparam int        AW       = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    i2c_reg_file_if.slave bus,
    input  logic [AW-1:0] usr_addr,
    input  logic          usr_we,
    input  logic [7:0]    usr_wdata,
    output logic [7:0]    usr_rdata,
    output logic          busy,
    output logic          irq
);

    typedef enum logic [1:0] {
        IDLE,
        GET_PTR,
        DATA
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [AW-1:0] ptr;
    logic [AW-1:0] ptr_next;
    logic [7:0]    regs [NUM_REGS];
    logic [7:0]    ptr_byte;
    logic [7:0]    usr_byte;
    logic          i2c_wr;
    logic          i2c_commit;
    logic          usr_commit;
    logic          tx_load;
    logic [7:0]    tx_byte;

    // Reg 0 is never stored; it always reads back as the device ID.
    assign ptr_byte   = (ptr == '0) ? DEV_ID : regs[ptr];
    assign usr_byte   = (usr_addr == '0) ? DEV_ID : regs[usr_addr];
    assign i2c_commit = i2c_wr && (ptr != '0);
    assign usr_commit = usr_we && (usr_addr != '0) && !(i2c_commit && (usr_addr == ptr));
    assign busy       = (state != IDLE);

    always_comb begin
        state_next = state;
        ptr_next   = ptr;
        i2c_wr     = 1'b0;
        tx_load    = 1'b0;
        tx_byte    = 8'hFF;
        unique case (state)
            IDLE: begin
                tx_load = bus.tx_req;
            end
            GET_PTR: begin
                if (bus.rx_valid) begin
                    ptr_next   = bus.rx_data[AW-1:0];
                    state_next = DATA;
                    tx_load    = bus.tx_req;
                end else if (bus.tx_req) begin
                    tx_load    = 1'b1;
                    tx_byte    = ptr_byte;
                    ptr_next   = ptr + AW'(1);
                    state_next = DATA;
                end
            end
            DATA: begin
                if (bus.rx_valid) begin
                    i2c_wr   = 1'b1;
                    ptr_next = ptr + AW'(1);
                    tx_load  = bus.tx_req;
                end else if (bus.tx_req) begin
                    tx_load  = 1'b1;
                    tx_byte  = ptr_byte;
                    ptr_next = ptr + AW'(1);
                end
            end
            default: state_next = IDLE;
        endcase
        // A (repeated) START overrides STOP arriving in the same cycle.
        if (bus.i2c_start) begin
            state_next = GET_PTR;
        end else if (bus.i2c_stop) begin
            state_next = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            ptr         <= '0;
            bus.tx_valid <= 1'b0;
            bus.tx_data  <= 8'h00;
            usr_rdata   <= 8'h00;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= 8'h00;
            end
        end else begin
            state        <= state_next;
            ptr          <= ptr_next;
            bus.tx_valid <= tx_load;
            if (tx_load) begin
                bus.tx_data <= tx_byte;
            end
            usr_rdata <= usr_byte;
            if (i2c_commit) begin
                regs[ptr] <= bus.rx_data;
            end
            if (usr_commit) begin
                regs[usr_addr] <= usr_wdata;
            end
        end
    end

`ifdef I2C_REGFILE_IRQ_EN
    logic dirty;

    // Dirty tracks committed I2C data writes within the current transaction.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dirty <= 1'b0;
            irq   <= 1'b0;
        end else begin
            irq <= bus.i2c_stop && !bus.i2c_start && dirty;
            if (bus.i2c_start) begin
                dirty <= 1'b0;
            end else if (i2c_commit) begin
                dirty <= 1'b1;
            end
        end
    end
`else
    assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_i2c_reg_file.sv
// Directed self-checking bench for i2c_reg_file; irq expectations follow I2C_REGFILE_IRQ_EN.
module tb_i2c_reg_file;

    logic       clk;
    logic       rst_n;
    logic [4:0] usr_addr;
    logic       usr_we;
    logic [7:0] usr_wdata;
    logic [7:0] usr_rdata;
    logic       busy;
    logic       irq;
    int         checks;
    int         failures;

    i2c_reg_file_if bus ();

    i2c_reg_file #(
        .NUM_REGS (32),
        .DEV_ID   (8'hA5)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus.slave),
        .usr_addr  (usr_addr),
        .usr_we    (usr_we),
        .usr_wdata (usr_wdata),
        .usr_rdata (usr_rdata),
        .busy      (busy),
        .irq       (irq)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic send_start();
        bus.i2c_start = 1'b1;
        tick();
        bus.i2c_start = 1'b0;
    endtask

    task automatic send_stop();
        bus.i2c_stop = 1'b1;
        tick();
        bus.i2c_stop = 1'b0;
    endtask

    task automatic send_rx(input logic [7:0] b);
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        tick();
        bus.rx_valid = 1'b0;
    endtask

    task automatic read_tx(input string tag, input logic [7:0] exp);
        bus.tx_req = 1'b1;
        tick();
        bus.tx_req = 1'b0;
        check({tag, "_valid"}, {7'd0, bus.tx_valid}, 8'h01);
        check({tag, "_data"}, bus.tx_data, exp);
    endtask

    task automatic usr_write(input logic [4:0] a, input logic [7:0] d);
        usr_addr  = a;
        usr_wdata = d;
        usr_we    = 1'b1;
        tick();
        usr_we    = 1'b0;
    endtask

    task automatic usr_read(input string tag, input logic [4:0] a, input logic [7:0] exp);
        usr_addr = a;
        tick();
        check(tag, usr_rdata, exp);
    endtask

    task automatic stop_and_check_irq(input string tag, input logic wrote);
        send_stop();
`ifdef I2C_REGFILE_IRQ_EN
        check({tag, "_irq"}, {7'd0, irq}, {7'd0, wrote});
        tick();
        check({tag, "_irq_end"}, {7'd0, irq}, 8'h00);
`else
        check({tag, "_irq"}, {7'd0, irq}, {7'd0, wrote & 1'b0});
`endif
        check({tag, "_busy"}, {7'd0, busy}, 8'h00);
    endtask

    initial begin
        checks        = 0;
        failures      = 0;
        rst_n         = 1'b0;
        usr_addr      = '0;
        usr_we        = 1'b0;
        usr_wdata     = '0;
        bus.i2c_start = 1'b0;
        bus.i2c_stop  = 1'b0;
        bus.rx_valid  = 1'b0;
        bus.rx_data   = '0;
        bus.tx_req    = 1'b0;
        tick();
        tick();
        check("rst_tx_valid", {7'd0, bus.tx_valid}, 8'h00);
        check("rst_tx_data", bus.tx_data, 8'h00);
        check("rst_usr_rdata", usr_rdata, 8'h00);
        check("rst_busy", {7'd0, busy}, 8'h00);
        check("rst_irq", {7'd0, irq}, 8'h00);
        rst_n = 1'b1;
        tick();

        // Idle read returns filler; reg 0 is the device ID and ignores fabric writes.
        read_tx("idle_tx", 8'hFF);
        tick();
        check("idle_tx_pulse_end", {7'd0, bus.tx_valid}, 8'h00);
        usr_write(5'd0, 8'h12);
        usr_read("devid", 5'd0, 8'hA5);
        usr_write(5'd7, 8'h77);
        usr_write(5'd1, 8'h5A);

        // Pointer write then two data bytes.
        send_start();
        check("start_busy", {7'd0, busy}, 8'h01);
        send_rx(8'h05);
        send_rx(8'h11);
        send_rx(8'h22);
        stop_and_check_irq("wr1", 1'b1);
        usr_read("reg5", 5'd5, 8'h11);
        usr_read("reg6", 5'd6, 8'h22);
        send_start();
        read_tx("ptr7_read", 8'h77);
        stop_and_check_irq("rd_only", 1'b0);

        // Pointer wraps past the top; the byte landing on reg 0 is dropped.
        send_start();
        send_rx(8'h1F);
        send_rx(8'hAA);
        send_rx(8'hBB);
        send_stop();
        usr_read("reg31", 5'd31, 8'hAA);
        usr_read("reg0_kept", 5'd0, 8'hA5);
        send_start();
        read_tx("wrap_ptr1", 8'h5A);
        send_stop();

        // Repeated-START read continues from the pointer just written.
        send_start();
        send_rx(8'h05);
        send_start();
        read_tx("rs_rd0", 8'h11);
        read_tx("rs_rd1", 8'h22);
        send_stop();

        // Simultaneous rx and tx request: the write lands, tx gets filler.
        send_start();
        send_rx(8'h0A);
        bus.tx_req = 1'b1;
        send_rx(8'h99);
        bus.tx_req = 1'b0;
        check("err_tx_valid", {7'd0, bus.tx_valid}, 8'h01);
        check("err_tx_data", bus.tx_data, 8'hFF);
        send_stop();
        usr_read("reg10", 5'd10, 8'h99);

        // Fabric vs I2C collisions: same reg I2C wins, different regs both commit.
        send_start();
        send_rx(8'h06);
        usr_addr  = 5'd6;
        usr_wdata = 8'h33;
        usr_we    = 1'b1;
        send_rx(8'h44);
        usr_addr  = 5'd9;
        usr_wdata = 8'h90;
        send_rx(8'h81);
        usr_we    = 1'b0;
        send_stop();
        usr_read("reg6_i2c_wins", 5'd6, 8'h44);
        usr_read("reg7_other", 5'd7, 8'h81);
        usr_read("reg9_usr", 5'd9, 8'h90);

        // START and STOP together leave the bank busy.
        bus.i2c_stop = 1'b1;
        send_start();
        bus.i2c_stop = 1'b0;
        check("start_wins_busy", {7'd0, busy}, 8'h01);
        send_stop();

        // Reset in the middle of a transaction suppresses the pending tx pulse.
        send_start();
        send_rx(8'h03);
        bus.tx_req = 1'b1;
        rst_n      = 1'b0;
        tick();
        bus.tx_req = 1'b0;
        check("midrst_tx_valid", {7'd0, bus.tx_valid}, 8'h00);
        check("midrst_busy", {7'd0, busy}, 8'h00);
        rst_n = 1'b1;
        usr_read("midrst_reg5", 5'd5, 8'h00);
        send_start();
        read_tx("midrst_ptr0", 8'hA5);
        send_stop();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
